// File: rtl/tick_pkg.sv
// tick_pkg: shared state encoding and synchronizer depth limits for tick consumers
package tick_pkg;
  typedef enum logic {IDLE, MEASURE} tick_state_t;
  localparam int SYNC_MIN = 1;
  localparam int SYNC_MAX = 4;
  function automatic int clamp_sync(int n);
    return n < SYNC_MIN ? SYNC_MIN : n > SYNC_MAX ? SYNC_MAX : n;
  endfunction
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: synchronizes an async strobe and pulses for one cycle on its rising edge
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);
  logic [STAGES-1:0] sync;
  logic hist;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync[0] <= d;
      for (int i = 1; i < STAGES; i++) sync[i] <= sync[i-1];
      hist <= sync[STAGES-1];
    end
  assign rise = sync[STAGES-1] & ~hist;
endmodule

// File: rtl/tick_period_meter.sv
// tick_period_meter: measures clk cycles between strobe rising edges, reported over valid/ready
module tick_period_meter
  import tick_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  output logic [WIDTH-1:0] period,
  output logic             valid,
  input  logic             ready,
  output logic             overflow,
  output logic             overrun,
  output logic             locked
);
  localparam logic [WIDTH-1:0] MAX = '1;
  tick_state_t state, state_nxt;
  logic rise, capture, have_prev;
  logic [WIDTH-1:0] count, count_nxt;
  sync_edge_detect #(.STAGES(clamp_sync(SYNC_STAGES))) u_sync (
    .clk(clk),
    .reset(reset),
    .d(tick_in),
    .rise(rise)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_comb state_nxt = (state == IDLE && rise) ? MEASURE : state;
  always_comb begin
    capture   = state == MEASURE && rise;
    count_nxt = rise ? WIDTH'(1) : (state == MEASURE && count != MAX) ? count + 1'b1 : count;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      count     <= '0;
      period    <= '0;
      valid     <= 1'b0;
      overflow  <= 1'b0;
      overrun   <= 1'b0;
      locked    <= 1'b0;
      have_prev <= 1'b0;
    end else begin
      count <= count_nxt;
      if (capture) begin
        period    <= count;
        overflow  <= count == MAX;
        overrun   <= valid && !ready;
        locked    <= have_prev && count == period && !overflow && count != MAX;
        valid     <= 1'b1;
        have_prev <= 1'b1;
      end else if (valid && ready) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
    end
endmodule
